result_narrower: RTL

Streaming narrower for the adder/accumulator result path. Accepts wide unsigned sums (RES_WIDTH bits) on a valid/ready input, applies an optional right shift with optional rounding, saturates to WIDTH bits and presents the narrowed value on a valid/ready output. It sits after the overflow-free adder tree, returning results to the operand width used by the rest of the matrix multiply engine, and counts saturation events for software.

---
 rtl/mme_pkg.sv | 14 +
 rtl/pipe_reg_stage.sv | 41 ++++
 rtl/result_narrower.sv | 86 ++++++++
 3 files changed

// File: rtl/mme_pkg.sv
// Shared constants and helpers for the matrix multiply engine result path.
package mme_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned MME_WIDTH     = 8;
  localparam int unsigned MME_RES_WIDTH = MME_WIDTH + clog2(MME_WIDTH);

endpackage

// File: rtl/pipe_reg_stage.sv
// One-entry valid/ready pipeline register; accepts whenever empty or draining.
module pipe_reg_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    valid_d    = valid_q;
    data_d     = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/result_narrower.sv
// Two-stage streaming narrower: shift/round into S1, saturate into S2, count clamps.
// Rounding (round-half-up) is enabled by defining NARROW_ROUND_EN; otherwise truncation.
module result_narrower
  import mme_pkg::*;
#(
  parameter int unsigned WIDTH     = MME_WIDTH,
  parameter int unsigned RES_WIDTH = MME_RES_WIDTH,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [RES_WIDTH-1:0] in_sum_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_sat_o,
  output logic                 out_last_o,
  output logic [CNT_WIDTH-1:0] sat_count_o
);

  localparam int unsigned TW = RES_WIDTH + 1;

`ifdef NARROW_ROUND_EN
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [TW-1:0] RND = (SHIFT > 0) ? (TW'(1) << RSH) : '0;
`else
  localparam logic [TW-1:0] RND = '0;
`endif

  logic [TW-1:0]    t;
  logic             s1_ready, s1_valid, s2_ready;
  logic [TW:0]      s1_q;
  logic             sat;
  logic [WIDTH-1:0] narrowed;
  logic [CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;

  // Extra top bit keeps the rounding carry from wrapping.
  always_comb t = ({1'b0, in_sum_i} + RND) >> SHIFT;

  pipe_reg_stage #(.DW(TW + 1)) u_s1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (s1_ready),
    .in_data_i   ({in_last_i, t}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_q)
  );

  always_comb begin
    sat      = |s1_q[TW-1:WIDTH];
    narrowed = sat ? '1 : s1_q[WIDTH-1:0];
  end

  pipe_reg_stage #(.DW(WIDTH + 2)) u_s2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   ({s1_q[TW], sat, narrowed}),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  ({out_last_o, out_sat_o, out_data_o})
  );

  assign in_ready_o = s1_ready && !rst_i;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (out_valid_o && out_ready_i && out_sat_o && (sat_cnt_q != '1))
      sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count_o = sat_cnt_q;

endmodule
